// File: rtl/mul_pkg.sv
// Shared definitions for the long-multiply sequencer and the instruction decoder.
package mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SIGN  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4
  } mul_state_e;

  localparam logic [3:0] ALU_UMULL = 4'b0110;
  localparam logic [3:0] ALU_SMULL = 4'b1000;

  localparam int MUL_WIDTH = 32;
  localparam int CNT_W     = $clog2(MUL_WIDTH);

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned 1-bit-per-cycle shift-add multiplier datapath: acc holds {partial product, multiplier}.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     sum;

  // The carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (load) begin
      mcand_q <= mcand_in;
      acc_q   <= {{WIDTH{1'b0}}, mplier_in};
    end else if (step) begin
      acc_q   <= {sum, acc_q[WIDTH-1:1]};
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_sequencer.sv
// UMULL/SMULL sequencer: magnitude shift-add multiply, sign fix-up, then RdLo/RdHi writeback.
// Handshake: start is a one-cycle request honoured only in IDLE; busy covers CALC..WB_HI.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [3:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             flag_we,
  output logic             flag_n,
  output logic             flag_z,
  output logic [2:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE2     = 1;
  localparam logic [WIDTH-1:0]   ONE1     = 1;

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         rd_lo_q, rd_hi_q;
  logic               set_flags_q, neg_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept;

  assign accept = (state_q == IDLE) && start;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + ONE1) : op_a;
  assign mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + ONE1) : op_b;

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state_q == CALC),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .acc       (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_lo_q     <= '0;
      rd_hi_q     <= '0;
      set_flags_q <= 1'b0;
      neg_q       <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q       <= '0;
        rd_lo_q     <= rd_lo;
        rd_hi_q     <= rd_hi;
        set_flags_q <= set_flags;
        neg_q       <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == SIGN) begin
        product_q <= neg_q ? (~acc + ONE2) : acc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = SIGN;
      SIGN:    state_d = WB_LO;
      WB_LO:   state_d = WB_HI;
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = 1'b0;
    we3     = 1'b0;
    wa3     = '0;
    wd3     = '0;
    flag_we = 1'b0;
    flag_n  = 1'b0;
    flag_z  = 1'b0;
    case (state_q)
      WB_LO: begin
        we3 = 1'b1;
        wa3 = rd_lo_q;
        wd3 = product_q[WIDTH-1:0];
      end
      WB_HI: begin
        we3     = 1'b1;
        wa3     = rd_hi_q;
        wd3     = product_q[2*WIDTH-1:WIDTH];
        done    = 1'b1;
        flag_we = set_flags_q;
        flag_n  = set_flags_q & product_q[2*WIDTH-1];
        flag_z  = set_flags_q & (product_q == '0);
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: 64-bit arithmetic reference, write/flag scoreboard, directed + random ops.
module tb_mul_sequencer;
  import mul_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, is_signed, set_flags;
  logic [W-1:0]  op_a, op_b;
  logic [3:0]    rd_lo, rd_hi;
  logic          busy, done, we3, flag_we, flag_n, flag_z;
  logic [3:0]    wa3;
  logic [W-1:0]  wd3;
  logic [2:0]    state_dbg;

  int checks = 0;
  int passes = 0;

  logic [W+3:0] exp_q[$];       // {addr, data} per expected register write
  logic [2:0]   exp_flag_q[$];  // {flag_we, flag_n, flag_z} per expected done
  logic [W-1:0] regs [16];

  mul_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .set_flags (set_flags),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_lo     (rd_lo),
    .rd_hi     (rd_hi),
    .busy      (busy),
    .done      (done),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .flag_we   (flag_we),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      regs[wa3] = wd3;
      if (exp_q.size() == 0) chk("unexpected_write", {28'b0, wa3, wd3}, 64'hDEAD);
      else begin
        logic [W+3:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(wa3), 64'(e[W+3:W]));
        chk("write_data", 64'(wd3), 64'(e[W-1:0]));
      end
    end
    if (done === 1'b1) begin
      if (exp_flag_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        logic [2:0] f;
        f = exp_flag_q.pop_front();
        chk("flag_we", 64'(flag_we), 64'(f[2]));
        if (f[2]) begin
          chk("flag_n", 64'(flag_n), 64'(f[1]));
          chk("flag_z", 64'(flag_z), 64'(f[0]));
        end
      end
    end else if (flag_we === 1'b1) begin
      chk("flag_we_without_done", 64'(flag_we), 64'd0);
    end
  end

  // driver: one operation, with optional stray start pulses while busy
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input logic sf, input logic [3:0] lo, input logic [3:0] hi,
                       input bit noisy);
    logic [63:0] p;
    int n;
    p = ref_prod(a, b, sg);
    exp_q.push_back({lo, p[W-1:0]});
    exp_q.push_back({hi, p[63:32]});
    exp_flag_q.push_back({sf, p[63], (p == 64'd0)});
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; is_signed = sg; set_flags = sf; rd_lo = lo; rd_hi = hi;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      if (noisy && n < 30) begin
        start = (n % 4 == 1);
        op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
        set_flags = $urandom_range(0, 1);
        rd_lo = 4'($urandom_range(0, 15)); rd_hi = 4'($urandom_range(0, 15));
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_latency", 64'(n), 64'd35);
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; set_flags = 1'b0;
    op_a = '0; op_b = '0; rd_lo = '0; rd_hi = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {56'b0, busy, done, we3, flag_we, flag_n, flag_z, 2'b0}, 64'd0);
    chk("reset_wa3_wd3", {28'b0, wa3, wd3}, 64'd0);
    chk("reset_state", 64'(state_dbg), 64'(IDLE));
    reset = 1'b0;

    // directed cases
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd7,         1'b1, 1'b0, 4'd2, 4'd3, 1'b0);
    chk("r2_smull", 64'(regs[2]), 64'hFFFF_FFF9);
    chk("r3_smull", 64'(regs[3]), 64'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd5, 4'd6, 1'b0);
    do_op(32'd0, 32'hFFFF_FFFB,         1'b1, 1'b1, 4'd7, 4'd8, 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 4'd9, 4'd10, 1'b1);
    do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 4'd4, 4'd4, 1'b0);
    chk("r4_last_write_wins", 64'(regs[4]), 64'd1);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 4'hF, 4'hE, 1'b0);

    // reset in the middle of CALC: nothing may be written afterwards
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'hCAFE_F00D; op_b = 32'h1234_5678; is_signed = 1'b0;
    set_flags = 1'b1; rd_lo = 4'd11; rd_hi = 4'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {56'b0, busy, done, we3, flag_we, flag_n, flag_z, 2'b0}, 64'd0);
    chk("abort_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_writes", 64'(regs[11]), 64'd0);
    do_op(32'd3, 32'd5, 1'b0, 1'b0, 4'd11, 4'd12, 1'b0);

    // randomized operations, including back-to-back and stray starts
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("write_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("flag_queue_drained", 64'(exp_flag_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
